mem_arbiter: RTL

- Arbitrates one shared main-memory port between the instruction-cache fill path and the data-cache fill/writeback path. These are the two miss sources behind the processor's i_hit/d_hit stalls.
- Moves one 64-bit line (4 x 16-bit words) per transaction against a fixed-latency synchronous memory.
- Returns a one-cycle ready/done pulse to the winning requester.
- Sits between the cache controllers and main memory; the processor pipeline stalls on cache misses while this block works.

---
 rtl/mem_arbiter.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Shared main-memory arbiter between I-cache fill and D-cache fill/writeback paths.
// Optional round-robin DR/IW tie-breaking is enabled with the MEM_ARB_RR_EN macro.
module mem_arbiter #(
  parameter int MEM_LAT = 4,
  parameter int ADDR_W  = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_rdy,
  output logic [63:0]       i_line,
  input  logic              d_re,
  input  logic [ADDR_W-1:0] d_raddr,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_waddr,
  input  logic [63:0]       d_wdata,
  output logic              d_rdy,
  output logic [63:0]       d_line,
  output logic              d_wdone,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic [1:0] {OWN_IW, OWN_DR, OWN_DW} owner_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  owner_t              grant_s;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [63:0]         mem_wdata_q, mem_wdata_d;
  logic                mem_re_q, mem_re_d;
  logic                mem_we_q, mem_we_d;
  logic                i_rdy_q, i_rdy_d;
  logic                d_rdy_q, d_rdy_d;
  logic                d_wdone_q, d_wdone_d;
  logic [63:0]         i_line_q, i_line_d;
  logic [63:0]         d_line_q, d_line_d;
  logic                busy_q, busy_d;
`ifdef MEM_ARB_RR_EN
  logic                last_d_q, last_d_d;  // 1: last DR/IW grant went to the D side
`endif

  // Request selection: writeback always wins; DR/IW ties by priority or round-robin.
  always_comb begin
    grant_s = OWN_IW;
    if (d_we) begin
      grant_s = OWN_DW;
    end else if (d_re && i_re) begin
`ifdef MEM_ARB_RR_EN
      grant_s = last_d_q ? OWN_IW : OWN_DR;
`else
      grant_s = OWN_DR;
`endif
    end else if (d_re) begin
      grant_s = OWN_DR;
    end else begin
      grant_s = OWN_IW;
    end
  end

  // Next-state and registered-output logic for the IDLE/BUSY/DONE sequencer.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    i_rdy_d     = 1'b0;
    d_rdy_d     = 1'b0;
    d_wdone_d   = 1'b0;
    i_line_d    = i_line_q;
    d_line_d    = d_line_q;
    busy_d      = busy_q;
`ifdef MEM_ARB_RR_EN
    last_d_d    = last_d_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (d_we || d_re || i_re) begin
          state_d = S_BUSY;
          busy_d  = 1'b1;
          cnt_d   = CNT_INIT;
          owner_d = grant_s;
          case (grant_s)
            OWN_DW: begin
              mem_addr_d  = d_waddr;
              mem_wdata_d = d_wdata;
              mem_we_d    = 1'b1;
            end
            OWN_DR: begin
              mem_addr_d = d_raddr;
              mem_re_d   = 1'b1;
`ifdef MEM_ARB_RR_EN
              last_d_d   = 1'b1;
`endif
            end
            default: begin
              mem_addr_d = i_addr;
              mem_re_d   = 1'b1;
`ifdef MEM_ARB_RR_EN
              last_d_d   = 1'b0;
`endif
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        // Read data is valid in the cycle the countdown reaches zero.
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          case (owner_q)
            OWN_IW: begin
              i_line_d = mem_rdata;
              i_rdy_d  = 1'b1;
            end
            OWN_DR: begin
              d_line_d = mem_rdata;
              d_rdy_d  = 1'b1;
            end
            OWN_DW: begin
              d_wdone_d = 1'b1;
            end
            default: begin
              d_wdone_d = 1'b0;
            end
          endcase
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IW;
      cnt_q       <= 4'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 64'd0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      i_rdy_q     <= 1'b0;
      d_rdy_q     <= 1'b0;
      d_wdone_q   <= 1'b0;
      i_line_q    <= 64'd0;
      d_line_q    <= 64'd0;
      busy_q      <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_d_q    <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      i_rdy_q     <= i_rdy_d;
      d_rdy_q     <= d_rdy_d;
      d_wdone_q   <= d_wdone_d;
      i_line_q    <= i_line_d;
      d_line_q    <= d_line_d;
      busy_q      <= busy_d;
`ifdef MEM_ARB_RR_EN
      last_d_q    <= last_d_d;
`endif
    end
  end

  assign i_rdy     = i_rdy_q;
  assign i_line    = i_line_q;
  assign d_rdy     = d_rdy_q;
  assign d_line    = d_line_q;
  assign d_wdone   = d_wdone_q;
  assign mem_addr  = mem_addr_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule
